// File: rtl/univ_shift_reg.sv
// Universal shift register with burst control.
// Supports parallel load, logical shift left/right and rotate left/right.
// A shift or rotate burst moves the register one bit position per clock,
// for a count latched with the command. The burst reports busy while it
// runs, pulses done when it finishes, and can be cut short by abort.
// Optional feature: define ARITH_SHIFT_EN to make mode 3'b110 an
// arithmetic right shift. Without it, mode 3'b110 behaves as hold.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] din_par,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    output logic [WIDTH-1:0] Q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    state_t           state, next_state;
    logic [WIDTH-1:0] q_reg, next_q;
    logic [CNT_W-1:0] rem, next_rem;
    logic [2:0]       mode_r, next_mode;
    logic             done_r, next_done;

    // A mode needs a multi-cycle burst only if it moves bits.
    function automatic logic is_burst(input logic [2:0] m);
        logic r;
        r = 1'b0;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
`ifdef ARITH_SHIFT_EN
            MODE_ASR: r = 1'b1;
`else
            MODE_ASR: r = 1'b0;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Move the register by one bit position in the direction the mode selects.
    function automatic logic [WIDTH-1:0] step(input logic [2:0] m,
                                              input logic [WIDTH-1:0] v,
                                              input logic sl,
                                              input logic sm);
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            MODE_SHL: r = {v[WIDTH-2:0], sl};
            MODE_SHR: r = {sm, v[WIDTH-1:1]};
            MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: r = {v[0], v[WIDTH-1:1]};
`ifdef ARITH_SHIFT_EN
            MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
`endif
            default:  r = v;
        endcase
        return r;
    endfunction

    // Register the state, datapath, and burst bookkeeping; done defaults low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q_reg  <= '0;
            rem    <= '0;
            mode_r <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= next_state;
            q_reg  <= next_q;
            rem    <= next_rem;
            mode_r <= next_mode;
            done_r <= next_done;
        end
    end

    // Decode commands in IDLE and step the burst in RUN. An abort wins over the shift.
    always_comb begin
        next_state = state;
        next_q     = q_reg;
        next_rem   = rem;
        next_mode  = mode_r;
        next_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode == MODE_LOAD) begin
                        next_q    = din_par;
                        next_done = 1'b1;
                    end else if (is_burst(mode) && (cnt != '0)) begin
                        next_state = RUN;
                        next_rem   = cnt;
                        next_mode  = mode;
                    end else begin
                        next_done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                    next_rem   = '0;
                end else begin
                    next_q   = step(mode_r, q_reg, sin_lsb, sin_msb);
                    next_rem = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign Q        = q_reg;
    assign sout_msb = q_reg[WIDTH-1];
    assign sout_lsb = q_reg[0];
    assign busy     = (state == RUN);
    assign done     = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard testbench for univ_shift_reg (WIDTH=8, CNT_W=4).
// The stimulus process pushes the expected final register value and busy
// length for every command that should end in done. A separate monitor
// checks each done pulse against the scoreboard.
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [2:0]       mode;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] din_par;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] Q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        int               busy_cycles;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model_q;
    int               checks;
    int               failures;

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .cnt(cnt), .din_par(din_par), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
        .Q(Q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit modelIsBurst(input logic [2:0] m);
`ifdef ARITH_SHIFT_EN
        return (m >= 3'd2) && (m <= 3'd6);
`else
        return (m >= 3'd2) && (m <= 3'd5);
`endif
    endfunction

    // Closed-form result of a whole command, computed with integer arithmetic.
    function automatic logic [WIDTH-1:0] modelResult(input logic [2:0] m, input int n,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] d,
                                                     input logic sl, input logic sm);
        longint mask, v, r, fill;
        int rot;
        mask = (longint'(1) << WIDTH) - 1;
        v    = longint'(q);
        r    = v;
        rot  = n % WIDTH;
        case (m)
            3'd1: r = longint'(d);
            3'd2: begin
                fill = sl ? ((longint'(1) << n) - 1) : 0;
                r = ((v << n) | fill) & mask;
            end
            3'd3: begin
                fill = sm ? (mask & ~(mask >> n)) : 0;
                r = (v >> n) | fill;
            end
            3'd4: r = ((v << rot) | (v >> (WIDTH - rot))) & mask;
            3'd5: r = ((v >> rot) | (v << (WIDTH - rot))) & mask;
`ifdef ARITH_SHIFT_EN
            3'd6: begin
                fill = q[WIDTH-1] ? (mask & ~(mask >> n)) : 0;
                r = (v >> n) | fill;
            end
`endif
            default: r = v;
        endcase
        return r[WIDTH-1:0];
    endfunction

    // Issue one command; abort_after>0 cuts a burst after that many shifts.
    task automatic applyStimulus(input logic [2:0] m, input logic [CNT_W-1:0] n,
                                 input logic [WIDTH-1:0] d, input logic sl,
                                 input logic sm, input int abort_after,
                                 input bit poke_start);
        exp_t e;
        int   guard;
        bit   bursting;
        bursting = modelIsBurst(m) && (n != 0);
        @(posedge clk);
        #1;
        mode = m; cnt = n; din_par = d; sin_lsb = sl; sin_msb = sm; start = 1'b1;
        if (bursting && abort_after > 0 && abort_after < int'(n)) begin
            e.q = modelResult(m, abort_after, model_q, d, sl, sm);
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < abort_after; i++) begin
                @(posedge clk);
                #1;
                if (poke_start && i == 0) begin
                    start = 1'b1; mode = 3'b001; din_par = ~d; cnt = ~n;
                end else begin
                    start = 1'b0; mode = m; din_par = d; cnt = n;
                end
            end
            start = 1'b0;
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            checkOutput("abort_q", 32'(Q), 32'(e.q));
            checkOutput("abort_busy", 32'(busy), 32'd0);
            model_q = e.q;
            repeat (2) @(posedge clk);
        end else begin
            e.q = modelResult(m, int'(n), model_q, d, sl, sm);
            e.busy_cycles = bursting ? int'(n) : 0;
            sb.push_back(e);
            model_q = e.q;
            @(posedge clk);
            #1;
            start = 1'b0;
            guard = 0;
            while (busy && guard < 40) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 40) checkOutput("busy_timeout", 32'd1, 32'd0);
            repeat (2) @(posedge clk);
        end
    endtask

    // Monitor: at every done pulse, pop the scoreboard and compare.
    initial begin : monitor
        int  busy_cnt;
        bit  prev_busy;
        exp_t e;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_q", 32'(Q), 32'(e.q));
                        checkOutput("done_sout_msb", 32'(sout_msb), 32'(e.q[WIDTH-1]));
                        checkOutput("done_sout_lsb", 32'(sout_lsb), 32'(e.q[0]));
                        checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
                        checkOutput("busy_at_done", 32'(busy), 32'd0);
                    end
                    busy_cnt = 0;
                end else if (prev_busy && !busy) begin
                    busy_cnt = 0;
                end
                if (busy) busy_cnt++;
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        int ab;
        checks = 0; failures = 0; model_q = '0;
        rst = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; cnt = '0;
        din_par = '0; sin_lsb = 1'b0; sin_msb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_q", 32'(Q), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] directed tests");
        applyStimulus(3'b001, 4'd9, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b001, 4'd0, 8'h81, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b010, 4'd3, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(3'b001, 4'd0, 8'h81, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b101, 4'd1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b001, 4'd0, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b100, 4'd15, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b001, 4'd0, 8'hF0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b011, 4'd6, 8'h00, 1'b0, 1'b0, 2, 1'b1);
        applyStimulus(3'b001, 4'd0, 8'h90, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(3'b110, 4'd2, 8'h00, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(3'b000, 4'd5, 8'h3C, 1'b1, 1'b1, 0, 1'b0);
        applyStimulus(3'b111, 4'd5, 8'h3C, 1'b1, 1'b1, 0, 1'b0);
        applyStimulus(3'b010, 4'd0, 8'h3C, 1'b1, 1'b1, 0, 1'b0);

        $display("[TB] asynchronous reset during a burst");
        applyStimulus(3'b001, 4'd0, 8'h5A, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        mode = 3'b100; cnt = 4'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrun_reset_q", 32'(Q), 32'd0);
        checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
        checkOutput("midrun_reset_done", 32'(done), 32'd0);
        model_q = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] randomized commands");
        for (int k = 0; k < 40; k++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
            applyStimulus(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                          8'($urandom), 1'($urandom), 1'($urandom), ab, 1'($urandom));
        end

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
